// File: rtl/soin_pkg.sv
// Shared types and byte-enable constants for the load/store alignment unit.
package soin_pkg;

    localparam int unsigned DATA_W = 32;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [DATA_W-1:0] addr_t;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BEAT = 2'b01,
        DONE = 2'b10
    } lsu_state_e;

    // Byte-enable patterns the data memory accepts.
    localparam logic [3:0] MASK_W  = 4'b1111;
    localparam logic [3:0] MASK_H0 = 4'b0011;
    localparam logic [3:0] MASK_H1 = 4'b0110;
    localparam logic [3:0] MASK_H2 = 4'b1100;
    localparam logic [3:0] MASK_B0 = 4'b0001;
    localparam logic [3:0] MASK_B1 = 4'b0010;
    localparam logic [3:0] MASK_B2 = 4'b0100;
    localparam logic [3:0] MASK_B3 = 4'b1000;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (lsu_size_e'(sz))
            BYTE:    return 3'd1;
            HALF:    return 3'd2;
            WORD:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_beat_planner.sv
// Picks the widest legal byte-enable mask for one store beat and its byte count.
module lsu_beat_planner
    import soin_pkg::*;
(
    input  logic [1:0] lane_i,
    input  logic [2:0] remain_i,
    output logic [3:0] mask_o,
    output logic [2:0] k_o
);

    always_comb begin
        mask_o = '0;
        if (remain_i != 3'd0) begin
            case (lane_i)
                2'd0:    mask_o = (remain_i >= 3'd4) ? MASK_W :
                                  (remain_i >= 3'd2) ? MASK_H0 : MASK_B0;
                2'd1:    mask_o = (remain_i >= 3'd2) ? MASK_H1 : MASK_B1;
                2'd2:    mask_o = (remain_i >= 3'd2) ? MASK_H2 : MASK_B2;
                default: mask_o = MASK_B3;
            endcase
        end
        k_o = 3'($countones(mask_o));
    end

endmodule

// File: rtl/lsu_align_unit.sv
// Splits byte/half/word loads and stores at any address into word-addressed memory beats.
module lsu_align_unit
    import soin_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_req,
    output logic       o_ready,
    input  logic       i_we,
    input  logic [1:0] i_size,
    input  logic       i_unsigned,
    input  addr_t      i_addr,
    input  data_t      i_wdata,
    output logic       o_valid,
    output data_t      o_rdata,
    output logic       o_err,
    output addr_t      o_Addr,
    output data_t      o_Wd,
    output logic [3:0] o_Wen,
    output logic       o_Ren,
    input  data_t      i_Rd
);

    lsu_state_e state_q;
    addr_t      p_q;
    logic [2:0] n_q;
    logic [2:0] k_q;
    data_t      wd_q;
    data_t      lo_q;
    logic       we_q;
    logic       uns_q;
    lsu_size_e  size_q;
    logic [1:0] lane0_q;
    logic       first_q;

    logic       ready_q;
    logic       valid_q;
    logic       err_q;
    data_t      rdata_q;
    addr_t      addr_q;
    data_t      wd_out_q;
    logic [3:0] wen_q;
    logic       ren_q;

    addr_t      p_nx;
    logic [2:0] n_nx;
    data_t      wd_nx;
    logic       we_nx;
    logic       beat_go;
    logic [3:0] plan_mask;
    logic [2:0] plan_k;
    logic [2:0] room;
    logic [2:0] load_k;
    logic [2:0] beat_k;

    logic [2*XLEN-1:0] pair;
    data_t             merged;
    data_t             load_res;

    // Pointer/count/datum for the beat that starts at the coming edge.
    always_comb begin
        p_nx  = p_q + addr_t'(k_q);
        n_nx  = n_q - k_q;
        wd_nx = wd_q >> {k_q, 3'b000};
        we_nx = we_q;
        if (state_q == IDLE) begin
            p_nx  = i_addr;
            n_nx  = size_bytes(i_size);
            wd_nx = i_wdata;
            we_nx = i_we;
        end
        beat_go = (((state_q == IDLE) && i_req) || (state_q == BEAT)) && (n_nx != 3'd0);
        room    = 3'd4 - {1'b0, p_nx[1:0]};
        load_k  = (n_nx < room) ? n_nx : room;
        beat_k  = we_nx ? plan_k : load_k;
    end

    lsu_beat_planner u_planner (
        .lane_i   (p_nx[1:0]),
        .remain_i (n_nx),
        .mask_o   (plan_mask),
        .k_o      (plan_k)
    );

    // Little-endian merge of up to two read words, then sign/zero extension.
    always_comb begin
        pair   = first_q ? {XLEN'(0), i_Rd} : {i_Rd, lo_q};
        merged = XLEN'(pair >> {lane0_q, 3'b000});
        case (size_q)
            BYTE:    load_res = {{24{merged[7] & ~uns_q}}, merged[7:0]};
            HALF:    load_res = {{16{merged[15] & ~uns_q}}, merged[15:0]};
            default: load_res = merged;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            addr_q   <= '0;
            wd_out_q <= '0;
            wen_q    <= '0;
            ren_q    <= 1'b0;
            p_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            wd_q     <= '0;
            lo_q     <= '0;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            size_q   <= BYTE;
            lane0_q  <= '0;
            first_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req) begin
                        ready_q <= 1'b0;
                        we_q    <= i_we;
                        uns_q   <= i_unsigned;
                        size_q  <= lsu_size_e'(i_size);
                        lane0_q <= i_addr[1:0];
                        first_q <= 1'b1;
                        if (lsu_size_e'(i_size) == ILLEGAL) begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= BEAT;
                        end
                    end
                end
                BEAT: begin
                    first_q <= 1'b0;
                    if (first_q) begin
                        lo_q <= i_Rd;
                    end
                    if (n_nx == 3'd0) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        rdata_q <= we_q ? '0 : load_res;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase

            // Register the next beat's memory outputs; idle the bus otherwise.
            if (beat_go) begin
                p_q      <= p_nx;
                n_q      <= n_nx;
                k_q      <= beat_k;
                wd_q     <= wd_nx;
                addr_q   <= {p_nx[31:2], 2'b00};
                wen_q    <= we_nx ? plan_mask : 4'b0000;
                ren_q    <= ~we_nx;
                wd_out_q <= we_nx ? wd_nx : '0;
            end else begin
                addr_q   <= '0;
                wd_out_q <= '0;
                wen_q    <= '0;
                ren_q    <= 1'b0;
            end
        end
    end

    // A beat in flight when reset lands must not commit at that edge.
    assign o_Wen   = wen_q & {4{i_rstn}};
    assign o_Ren   = ren_q & i_rstn;
    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;
    assign o_rdata = rdata_q;
    assign o_Addr  = addr_q;
    assign o_Wd    = wd_out_q;

endmodule

// File: doc/lsu_align_unit.md
# lsu_align_unit

Load/store alignment unit sitting between the core's memory-stage request and the data memory. It turns one load or store of byte, halfword or word size at any byte address into a short sequence of word-addressed memory beats. Each beat uses only byte-enable patterns the data memory accepts. Loads are merged from up to two words and sign- or zero-extended; the unit is multi-cycle with a ready/valid handshake toward the core.

## Interface
Parameters:
- `XLEN`, 32: data and address width; only 32 is supported.

Ports:
- `i_clk`  in  1  clock
- `i_rstn`  in  1  reset, synchronous, active-low
- `i_req`  in  1  request valid
- `o_ready`  out  1  unit idle and able to accept a request
- `i_we`  in  1  1 = store, 0 = load
- `i_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `i_unsigned`  in  1  zero-extend load (lbu/lhu)
- `i_addr`  in  addr_t  byte address
- `i_wdata`  in  data_t  store datum, right-justified
- `o_valid`  out  1  one-cycle completion pulse
- `o_rdata`  out  data_t  extended load result, valid with `o_valid`
- `o_err`  out  1  illegal size, valid with `o_valid`
- `o_Addr`  out  addr_t  memory word address, bits [1:0] = 0
- `o_Wd`  out  data_t  beat write data, right-justified
- `o_Wen`  out  4  byte-lane write enable
- `o_Ren`  out  1  memory read enable
- `i_Rd`  in  data_t  memory read word, combinational from `o_Addr`/`o_Ren`

## Operation
- States are IDLE, BEAT and DONE.
- IDLE:
  - `o_ready`=1.
  - `i_req`&&`o_ready` at an edge latches the request.
  - Byte pointer p = `i_addr`; remaining count n = 1, 2 or 4 bytes.
  - Size 11: go to DONE with `o_err`=1 and no memory beat.
  - Otherwise go to BEAT.
- BEAT, store beat plan:
  - `o_Addr` = {p[31:2],2'b00}. Lane l = p[1:0]; m = min(n, 4-l).
  - Mask for l=0: 1111 if m=4; else 0011 if m≥2; else 0001.
  - Mask for l=1: 0110 if m≥2; else 0010.
  - Mask for l=2: 1100 if m≥2; else 0100.
  - Mask for l=3: 1000.
  - k = popcount(mask). `o_Wd` = latched wdata >> (8×bytes already written).
  - Then p += k, n -= k.
  - No other `o_Wen` pattern is ever driven. At most 3 beats.
- BEAT, load:
  - `o_Ren`=1, `o_Wen`=0.
  - Beat 1 reads word {p[31:2],00}.
  - If (p[1:0] + size bytes) > 4, beat 2 reads the next word.
  - Word address wraps 0xFFFFFFFC → 0x00000000.
  - `i_Rd` is captured at the end of each beat.
  - Bytes are merged little-endian from p, then sign-extended (from bit 7 or 15) unless `i_unsigned`.
- BEAT → DONE when n reaches 0.
- DONE:
  - `o_valid`=1 for exactly one cycle, `o_ready`=0.
  - `o_rdata` holds the load result; 0 for stores and errors.
  - DONE → IDLE.
- Memory outputs are 0 outside BEAT: `o_Wen`=0, `o_Ren`=0, `o_Addr`=0, `o_Wd`=0.
- Requests are ignored while `o_ready`=0.

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational path from `i_req` to memory outputs.
- Reset (`i_rstn`=0 at an edge):
  - State = IDLE, `o_ready`=1.
  - `o_valid`, `o_err`, `o_rdata`, `o_Addr`, `o_Wd`, `o_Wen` and `o_Ren` all 0.
- Latency, with the request accepted at edge E0:
  - Beats occupy cycles 1..B.
  - `o_valid` is asserted in cycle B+1.
  - `o_ready` returns in cycle B+2.
  - B = 1 for aligned or in-word accesses, 2 for word-crossing loads, and 1–3 for stores.
- Store beats commit at the edge ending each beat cycle.
- Reset mid-operation:
  - Remaining beats abort immediately.
  - Bytes already committed stay written; there is no rollback.
  - No `o_valid` is produced.
- Illegal size: `o_valid`=`o_err`=1 in cycle 1.

## Structure
- Shared package `soin_pkg` holds:
  - `data_t` and `addr_t`.
  - `lsu_size_e` (BYTE, HALF, WORD, ILLEGAL).
  - `lsu_state_e` (IDLE, BEAT, DONE).
  - Mask constants.
- One combinational sub-module, `lsu_beat_planner`:
  - Inputs are lane and remaining count.
  - Outputs are the 4-bit mask and the beat byte count k.
  - The FSM, pointer/count registers, data shifter and load merge/extend stay in `lsu_align_unit`.

## Test plan
- sw 0x100, wdata 0xDEADBEEF:
  - One beat: `o_Addr`=0x100, `o_Wen`=1111, `o_Wd`=0xDEADBEEF.
  - `o_valid` in cycle 2, `o_rdata`=0.
- sb 0x103, wdata 0x000000A5:
  - One beat: `o_Wen`=1000, `o_Wd`[7:0]=0xA5.
  - mem[0x100][31:24]=0xA5; other bytes unchanged.
- sw 0x101, wdata 0x44332211, three beats:
  - (0x100, 0110, 0x00443322_11 → `o_Wd`[15:0]=0x2211)
  - (0x100, 1000, `o_Wd`[7:0]=0x33)
  - (0x104, 0001, `o_Wd`[7:0]=0x44)
  - `o_valid` in cycle 4.
- lh 0x103 with mem[0x100]=0xAB000000 and mem[0x104]=0x000000FF:
  - Two read beats, `o_rdata`=0xFFFFFFAB.
  - lhu at the same address gives 0x0000FFAB.
  - lw 0xFFFFFFFE reads words 0xFFFFFFFC then 0x00000000.
- Reset mid-store: `i_rstn`=0 during beat 2 of the sw 0x101 case.
  - All outputs are 0 next cycle and `o_ready`=1.
  - Only bytes 0x101–0x102 are written; no `o_valid`.
- Illegal size and back-to-back handling: `i_size`=11.
  - `o_valid`=`o_err`=1 in cycle 1; `o_Wen`=`o_Ren`=0 throughout.
  - A second `i_req` held high during BEAT/DONE is accepted only once `o_ready` returns.
